// File: rtl/day_of_year_arbiter_if.sv
// Request/response bundle between date clients and the day-of-year arbiter.
// Operand buses are flat packed vectors with one slice per requester.
interface day_of_year_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ*6-1:0]  req_day_of_month;
    logic [NUM_REQ*4-1:0]  req_month;
    logic [NUM_REQ*11-1:0] req_year;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [ID_W-1:0]       rsp_id;
    logic [8:0]            rsp_day_of_year;
    logic                  rsp_error;

    // Client side: issues requests, consumes responses.
    modport master (
        output req_valid, req_day_of_month, req_month, req_year, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_day_of_year, rsp_error
    );

    // Arbiter side.
    modport slave (
        input  req_valid, req_day_of_month, req_month, req_year, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_day_of_year, rsp_error
    );
endinterface

// File: rtl/day_of_year_arbiter.sv
// Round-robin arbiter sharing one combinational day-of-year calculator.
// One transaction at a time: IDLE (grant) -> CALC (capture) -> RESP (hold).
module day_of_year_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    day_of_year_arbiter_if.slave bus,
    output logic [5:0]           calc_day_of_month,
    output logic [3:0]           calc_month,
    output logic [10:0]          calc_year,
    input  logic [8:0]           calc_day_of_year
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]         state;
    logic [ID_W-1:0]    ptr;
    logic [ID_W-1:0]    sel_id;
    logic [ID_W-1:0]    grant_idx;
    logic               grant_found;
    logic [ID_W:0]      cand;
    logic [NUM_REQ-1:0] req_ready_c;
    logic [5:0]         month_max;
    logic               op_error;

    logic               rsp_valid_q;
    logic [ID_W-1:0]    rsp_id_q;
    logic [8:0]         rsp_doy_q;
    logic               rsp_error_q;

    // First valid requester at or after the pointer, wrapping at NUM_REQ.
    // One extra bit on cand keeps the wrap correct for non-power-of-2 counts.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, ptr} + (ID_W+1)'(k);
            if (cand >= (ID_W+1)'(NUM_REQ))
                cand = cand - (ID_W+1)'(NUM_REQ);
            if (!grant_found && bus.req_valid[cand[ID_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[ID_W-1:0];
            end
        end
    end

    // Grant is combinational so the handshake completes in the IDLE cycle.
    always_comb begin
        req_ready_c = '0;
        if (state == IDLE && grant_found)
            req_ready_c[grant_idx] = 1'b1;
    end

    // Range check on the latched operands; Feb allows 29 regardless of year.
    always_comb begin
        case (calc_month)
            4'd1, 4'd3, 4'd5, 4'd7, 4'd8, 4'd10, 4'd12: month_max = 6'd31;
            4'd4, 4'd6, 4'd9, 4'd11:                     month_max = 6'd30;
            4'd2:                                        month_max = 6'd29;
            default:                                     month_max = 6'd0;
        endcase
        op_error = (month_max == 6'd0) || (calc_day_of_month == 6'd0) ||
                   (calc_day_of_month > month_max);
    end

    // Arbitration FSM, operand latch and response capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= IDLE;
            ptr               <= '0;
            sel_id            <= '0;
            calc_day_of_month <= 6'd1;
            calc_month        <= 4'd1;
            calc_year         <= 11'd0;
            rsp_valid_q       <= 1'b0;
            rsp_id_q          <= '0;
            rsp_doy_q         <= 9'd0;
            rsp_error_q       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        calc_day_of_month <= bus.req_day_of_month[grant_idx*6 +: 6];
                        calc_month        <= bus.req_month[grant_idx*4 +: 4];
                        calc_year         <= bus.req_year[grant_idx*11 +: 11];
                        sel_id            <= grant_idx;
                        ptr               <= (grant_idx == ID_W'(NUM_REQ-1)) ? '0
                                                                             : grant_idx + 1'b1;
                        state             <= CALC;
                    end
                end
                CALC: begin
                    rsp_doy_q   <= op_error ? 9'd0 : calc_day_of_year;
                    rsp_error_q <= op_error;
                    rsp_id_q    <= sel_id;
                    rsp_valid_q <= 1'b1;
                    state       <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready       = req_ready_c;
    assign bus.rsp_valid       = rsp_valid_q;
    assign bus.rsp_id          = rsp_id_q;
    assign bus.rsp_day_of_year = rsp_doy_q;
    assign bus.rsp_error       = rsp_error_q;
endmodule

// File: tb/tb_day_of_year_arbiter.sv
// Scoreboard bench for day_of_year_arbiter: directed requests push expected
// responses; a negedge monitor pops and compares on each response handshake.
module tb_day_of_year_arbiter;
    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  calc_day_of_month;
    logic [3:0]  calc_month;
    logic [10:0] calc_year;
    logic [8:0]  calc_day_of_year;

    day_of_year_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

    day_of_year_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
        .clk               (clk),
        .rst               (rst),
        .bus               (bus),
        .calc_day_of_month (calc_day_of_month),
        .calc_month        (calc_month),
        .calc_year         (calc_year),
        .calc_day_of_year  (calc_day_of_year)
    );

    always #5 clk = ~clk;

    // The external shared calculator (Gregorian leap rules).
    function automatic logic [8:0] calc_model(input logic [5:0] d, input logic [3:0] m,
                                              input logic [10:0] y);
        int cum [12] = '{0, 31, 59, 90, 120, 151, 181, 212, 243, 273, 304, 334};
        bit leap;
        if (m == 0 || m > 12) return 9'd0;
        leap = ((y % 4 == 0) && (y % 100 != 0)) || (y % 400 == 0);
        return 9'(cum[m-1] + int'(d) + ((leap && m > 2) ? 1 : 0));
    endfunction

    always_comb calc_day_of_year = calc_model(calc_day_of_month, calc_month, calc_year);

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [8:0]      doy;
        logic            err;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   passed = 0;
    int   total  = 0;
    int   cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Monitor: every accepted response must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && bus.rsp_valid && bus.rsp_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rsp", 32'd1, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("rsp_id",  32'(bus.rsp_id),          32'(mon_e.id));
                chk("rsp_doy", 32'(bus.rsp_day_of_year), 32'(mon_e.doy));
                chk("rsp_err", 32'(bus.rsp_error),       32'(mon_e.err));
            end
        end
    end

    task automatic set_ops(input int id, input logic [5:0] d, input logic [3:0] m,
                           input logic [10:0] y);
        bus.req_day_of_month[id*6 +: 6] = d;
        bus.req_month[id*4 +: 4]        = m;
        bus.req_year[id*11 +: 11]       = y;
        bus.req_valid[id]               = 1'b1;
    endtask

    // Issue one request and wait for its grant; returns just after the accept edge.
    task automatic send(input int id, input logic [5:0] d, input logic [3:0] m,
                        input logic [10:0] y, input logic [8:0] e_doy, input logic e_err,
                        input bit push);
        int n;
        exp_t e;
        set_ops(id, d, m, y);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.req_ready[id] && n < 50);
        chk("grant_onehot", 32'(bus.req_ready), 32'(1) << id);
        if (!bus.req_ready[id]) begin
            bus.req_valid[id] = 1'b0;
            return;
        end
        if (push) begin
            e.id = ID_W'(id); e.doy = e_doy; e.err = e_err;
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
        bus.req_valid[id] = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n;
        int   last;
        logic [8:0] s_doy;
        logic [ID_W-1:0] s_id;

        bus.req_valid = '0;
        bus.req_day_of_month = '0;
        bus.req_month = '0;
        bus.req_year = '0;
        bus.rsp_ready = 1'b1;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_id",    32'(bus.rsp_id), 32'd0);
        chk("rst_rsp_doy",   32'(bus.rsp_day_of_year), 32'd0);
        chk("rst_rsp_err",   32'(bus.rsp_error), 32'd0);
        chk("rst_calc_dom",  32'(calc_day_of_month), 32'd1);
        chk("rst_calc_mon",  32'(calc_month), 32'd1);
        chk("rst_calc_year", 32'(calc_year), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Single request and accept-to-valid latency
        send(0, 6'd1, 4'd2, 11'd2020, 9'd32, 1'b0, 1);
        chk("lat_calc_cycle", 32'(bus.rsp_valid), 32'd0);
        @(posedge clk); #1;
        chk("lat_rsp_cycle", 32'(bus.rsp_valid), 32'd1);
        drain();

        // Leap / century rules and the Feb-29 pass-through
        send(1, 6'd31, 4'd12, 11'd2020, 9'd366, 1'b0, 1);
        send(2, 6'd31, 4'd12, 11'd1900, 9'd365, 1'b0, 1);
        send(3, 6'd1,  4'd3,  11'd2000, 9'd61,  1'b0, 1);
        send(0, 6'd1,  4'd3,  11'd1900, 9'd60,  1'b0, 1);
        send(1, 6'd29, 4'd2,  11'd2021, 9'd60,  1'b0, 1);
        // Range errors
        send(2, 6'd5,  4'd13, 11'd2021, 9'd0, 1'b1, 1);
        send(3, 6'd31, 4'd4,  11'd2021, 9'd0, 1'b1, 1);
        send(0, 6'd1,  4'd0,  11'd2021, 9'd0, 1'b1, 1);
        send(1, 6'd0,  4'd5,  11'd2021, 9'd0, 1'b1, 1);
        drain();

        // Reset during CALC: no response, pointer back to 0
        send(0, 6'd10, 4'd1, 11'd2021, 9'd0, 1'b0, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("abort_req_ready", 32'(bus.req_ready), 32'd0);
        repeat (2) @(negedge clk);
        chk("abort_no_rsp", 32'(bus.rsp_valid), 32'd0);
        @(posedge clk); #1;
        set_ops(1, 6'd2, 4'd1, 11'd2021);
        send(0, 6'd3, 4'd1, 11'd2021, 9'd3, 1'b0, 1);
        send(1, 6'd2, 4'd1, 11'd2021, 9'd2, 1'b0, 1);
        drain();

        // Backpressure in RESP with a competing request pending
        bus.rsp_ready = 1'b0;
        send(2, 6'd15, 4'd3, 11'd2021, 9'd74, 1'b0, 1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.rsp_valid && n < 10);
        chk("bp_valid_seen", 32'(bus.rsp_valid), 32'd1);
        s_doy = bus.rsp_day_of_year;
        s_id  = bus.rsp_id;
        set_ops(3, 6'd20, 4'd1, 11'd2021);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_valid_hold", 32'(bus.rsp_valid), 32'd1);
            chk("bp_doy_hold",   32'(bus.rsp_day_of_year), 32'(s_doy));
            chk("bp_id_hold",    32'(bus.rsp_id), 32'(s_id));
            chk("bp_no_grant",   32'(bus.req_ready), 32'd0);
        end
        @(posedge clk); #1;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_no_grant", 32'(bus.req_ready), 32'd0);
        @(posedge clk); #1;
        chk("bp_valid_drop", 32'(bus.rsp_valid), 32'd0);
        chk("bp_data_kept",  32'(bus.rsp_day_of_year), 32'd74);
        send(3, 6'd20, 4'd1, 11'd2021, 9'd20, 1'b0, 1);
        drain();

        // Round robin with all requesters continuously valid
        for (int i = 0; i < NUM_REQ; i++)
            set_ops(i, 6'(i + 1), 4'd1, 11'd2021);
        last = 0;
        for (int g = 0; g < 5; g++) begin
            exp_t e;
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (bus.req_ready == '0 && n < 20);
            chk("rr_grant", 32'(bus.req_ready), 32'(1) << (g % NUM_REQ));
            if (g > 0) chk("rr_spacing", 32'(cyc - last), 32'd3);
            last = cyc;
            e.id = ID_W'(g % NUM_REQ); e.doy = 9'((g % NUM_REQ) + 1); e.err = 1'b0;
            exp_q.push_back(e);
            @(posedge clk);
        end
        #1;
        bus.req_valid = '0;
        drain();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
